// File: rtl/score_display_ctrl.sv
// Shares one external bin2bcd between both player scores and
// scans the latched BCD digits onto a 4-digit 7-segment display.
module score_display_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LZ      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] score_l,
  input  logic [3:0] score_r,
  output logic [3:0] conv_bin,
  input  logic [3:0] conv_bcd0,
  input  logic [3:0] conv_bcd1,
  output logic [3:0] digit_bcd,
  output logic [3:0] an,
  output logic       busy,
  output logic       upd_done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    CAPT
  } state_t;

  localparam int SW = (SETTLE_CYCLES > 1) ?
                      $clog2(SETTLE_CYCLES) : 1;
  localparam int CW = $clog2(REFRESH_DIV);

  state_t state, state_nxt;

  logic [SW-1:0]   scnt;
  logic [3:0]      shadow_l;
  logic [3:0]      shadow_r;
  logic [3:0]      snap;
  logic            sel;
  logic            last_srv;
  logic [3:0][3:0] dig;
  logic [CW-1:0]   cnt;
  logic [1:0]      idx;

  logic pend_l;
  logic pend_r;
  logic pick_r;
  logic blank;

  // sel / last_srv: 1 = right player, 0 = left player
  always_comb begin
    pend_l = (score_l != shadow_l);
    pend_r = (score_r != shadow_r);
    pick_r = pend_r && !(pend_l && last_srv);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (pend_l || pend_r) state_nxt = LOAD;
      LOAD:
        state_nxt = SETTLE;
      SETTLE:
        if (scnt == SW'(SETTLE_CYCLES - 1))
          state_nxt = CAPT;
      CAPT:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      conv_bin <= '0;
      snap     <= '0;
      sel      <= 1'b0;
      last_srv <= 1'b1;
      shadow_l <= '0;
      shadow_r <= '0;
      dig      <= '0;
      scnt     <= '0;
      upd_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      upd_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pend_l || pend_r) begin
            conv_bin <= pick_r ? score_r : score_l;
            snap     <= pick_r ? score_r : score_l;
            sel      <= pick_r;
            scnt     <= '0;
          end
        end
        SETTLE:
          scnt <= scnt + 1'b1;
        CAPT: begin
          if (sel) begin
            dig[1]   <= conv_bcd1;
            dig[0]   <= conv_bcd0;
            shadow_r <= snap;
          end else begin
            dig[3]   <= conv_bcd1;
            dig[2]   <= conv_bcd0;
            shadow_l <= snap;
          end
          last_srv <= sel;
          upd_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // odd indices are tens digits
  assign blank = BLANK_LZ && idx[0] && (dig[idx] == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      an        <= 4'b1111;
      digit_bcd <= '0;
    end else begin
      if (cnt == CW'(REFRESH_DIV - 1)) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      digit_bcd <= dig[idx];
      an        <= blank ? 4'b1111 : ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Randomized scoreboard bench for score_display_ctrl with a
// high-level model of arbitration order and displayed digits.
module tb_score_display_ctrl;

  localparam int S  = 2;
  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] score_l = '0;
  logic [3:0] score_r = '0;
  logic [3:0] conv_bin;
  logic [3:0] conv_bcd0;
  logic [3:0] conv_bcd1;
  logic [3:0] digit_bcd;
  logic [3:0] an;
  logic       busy;
  logic       upd_done;

  score_display_ctrl #(
    .SETTLE_CYCLES(S),
    .REFRESH_DIV  (RD),
    .BLANK_LZ     (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .score_l  (score_l),
    .score_r  (score_r),
    .conv_bin (conv_bin),
    .conv_bcd0(conv_bcd0),
    .conv_bcd1(conv_bcd1),
    .digit_bcd(digit_bcd),
    .an       (an),
    .busy     (busy),
    .upd_done (upd_done)
  );

  // external bin2bcd stand-in
  assign conv_bcd0 = 4'(conv_bin % 4'd10);
  assign conv_bcd1 = 4'(conv_bin / 4'd10);

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int sh_l = 0;
  int sh_r = 0;
  bit last_r = 1'b1;

  task automatic chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && upd_done) begin
      if (exp_q.size() == 0) chk("unexpected_upd", 1, 0);
      else chk("conv_value", int'(conv_bin), exp_q.pop_front());
    end
  end

  // service order: a single request goes first; two at once
  // alternate with whichever side was served last
  task automatic model_issue(int nl, int nr);
    bit pl = (nl != sh_l);
    bit pr = (nr != sh_r);
    if (pl && pr) begin
      if (last_r) begin
        exp_q.push_back(nl); exp_q.push_back(nr); last_r = 1'b1;
      end else begin
        exp_q.push_back(nr); exp_q.push_back(nl); last_r = 1'b0;
      end
    end else if (pl) begin
      exp_q.push_back(nl); last_r = 1'b0;
    end else if (pr) begin
      exp_q.push_back(nr); last_r = 1'b1;
    end
    sh_l = nl;
    sh_r = nr;
  endtask

  task automatic wait_quiet();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("quiet_timeout", t, 0);
    repeat (3) @(negedge clk);
    chk("idle_after", int'(busy), 0);
  endtask

  task automatic apply(int nl, int nr);
    @(negedge clk);
    model_issue(nl, nr);
    score_l = 4'(nl);
    score_r = 4'(nr);
    wait_quiet();
  endtask

  task automatic wait_busy();
    int t = 0;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("busy_timeout", t, 0);
  endtask

  task automatic mid_change(bit side_r, int v1, int v2);
    @(negedge clk);
    if (side_r) begin
      model_issue(sh_l, v1); score_r = 4'(v1);
    end else begin
      model_issue(v1, sh_r); score_l = 4'(v1);
    end
    wait_busy();
    repeat (2) @(negedge clk);
    if (side_r) begin
      model_issue(sh_l, v2); score_r = 4'(v2);
    end else begin
      model_issue(v2, sh_r); score_l = 4'(v2);
    end
    wait_quiet();
  endtask

  task automatic scan_check();
    int d[4];
    int vis[4];
    int ix;
    d[3] = sh_l / 10; d[2] = sh_l % 10;
    d[1] = sh_r / 10; d[0] = sh_r % 10;
    for (int i = 0; i < 4; i++) vis[i] = 0;
    for (int k = 0; k < 4 * RD; k++) begin
      @(negedge clk);
      ix = -1;
      case (an)
        4'b1110: ix = 0;
        4'b1101: ix = 1;
        4'b1011: ix = 2;
        4'b0111: ix = 3;
        4'b1111: chk("blank_digit", int'(digit_bcd), 0);
        default: chk("an_pattern", int'(an), 14);
      endcase
      if (ix >= 0) begin
        chk("digit_bcd", int'(digit_bcd), d[ix]);
        vis[ix]++;
      end
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("scan_count%0d", i), vis[i],
          ((i % 2 == 1) && d[i] == 0) ? 0 : RD);
  endtask

  initial begin
    int nl, nr, v1, v2, busy_cyc, got, edges;
    bit sr;

    // reset held with nonzero scores
    score_l = 4'd5;
    score_r = 4'd5;
    repeat (4) @(negedge clk);
    chk("rst_an", int'(an), 15);
    chk("rst_digit", int'(digit_bcd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_conv_bin", int'(conv_bin), 0);
    chk("rst_upd", int'(upd_done), 0);
    rst = 1'b0;
    model_issue(5, 5);
    wait_quiet();
    scan_check();

    // single-side latency and busy width
    apply(0, 5);
    @(negedge clk);
    model_issue(7, sh_r);
    score_l = 4'd7;
    busy_cyc = 0;
    got = 0;
    edges = 0;
    repeat (S + 6) begin
      @(negedge clk);
      edges++;
      if (busy) busy_cyc++;
      if (upd_done && got == 0) got = edges;
    end
    chk("latency", got, S + 3);
    chk("busy_cycles", busy_cyc, S + 2);
    wait_quiet();
    scan_check();

    // simultaneous changes, round robin
    apply(9, 3);
    apply(10, 12);
    scan_check();
    apply(11, 13);
    scan_check();

    // change during SETTLE
    apply(9, 4);
    mid_change(1'b1, 5, 6);
    scan_check();

    // blanking pattern L=12 R=3
    apply(12, 3);
    scan_check();

    // randomized traffic
    for (int it = 0; it < 24; it++) begin
      nl = ($urandom % 3 == 0) ? sh_l : int'($urandom_range(0, 15));
      nr = ($urandom % 3 == 0) ? sh_r : int'($urandom_range(0, 15));
      apply(nl, nr);
      if (it % 4 == 3) scan_check();
      if (it % 6 == 5) begin
        sr = 1'(($urandom % 2));
        v1 = (((sr ? sh_r : sh_l) + 1 + int'($urandom_range(0, 13))) % 16);
        v2 = (v1 + 1 + int'($urandom_range(0, 13))) % 16;
        mid_change(sr, v1, v2);
        scan_check();
      end
    end

    // reset during SETTLE
    @(negedge clk);
    score_l = 4'(sh_l == 14 ? 2 : 14);
    model_issue(int'(score_l), sh_r);
    wait_busy();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", int'(an), 15);
    chk("arst_digit", int'(digit_bcd), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_conv_bin", int'(conv_bin), 0);
    chk("arst_upd", int'(upd_done), 0);
    exp_q.delete();
    sh_l = 0;
    sh_r = 0;
    last_r = 1'b1;
    if (score_r == 4'd0) score_r = 4'd8;
    repeat (3) @(negedge clk);
    chk("arst_upd_hold", int'(upd_done), 0);
    rst = 1'b0;
    model_issue(int'(score_l), int'(score_r));
    wait_quiet();
    scan_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
